// File: rtl/usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if.sv
// Bundle between the DCT packer and its trace source / trace FIFO consumer.
// master drives atoms, flush and frame_ready; slave is the packer.
interface usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if #(
    parameter int ATOM_W = 2,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
);
    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              atom_ready;
    logic              flush;
    logic              frame_valid;
    logic              frame_ready;
    logic [BUF_W-1:0]  frame_data;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_last;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_ending;
    logic              test_has_ended;

    modport master (
        output atom_valid, atom_data, flush, frame_ready,
        input  atom_ready, frame_valid, frame_data, frame_count, frame_last,
               dct_buffer, dct_count, test_ending, test_has_ended
    );

    modport slave (
        input  atom_valid, atom_data, flush, frame_ready,
        output atom_ready, frame_valid, frame_data, frame_count, frame_last,
               dct_buffer, dct_count, test_ending, test_has_ended
    );
endinterface

// File: rtl/usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames; full or flushed frames move to a one-deep output slot.
// Latency: a full buffer transfers on the next edge when the slot is free. Backpressure: atom_ready drops while the buffer is full.
module usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic reset,
    usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if.slave bus
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);

    // PEND: flush waiting for its frame; SENT: flushed frame sits in the slot
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SENT} state_t;

    state_t            state_q, state_n;
    logic [BUF_W-1:0]  pack_q, pack_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [CNT_W-1:0]  base_cnt;
    logic              frame_valid_q;
    logic              frame_last_q;
    logic [BUF_W-1:0]  frame_data_q;
    logic [CNT_W-1:0]  frame_count_q;
    logic              ended_q, ended_n;

    logic atom_ready;
    logic accept;
    logic slot_free;
    logic xfer;
    logic handshake;

    assign atom_ready = (cnt_q != FULL);
    assign accept     = bus.atom_valid && atom_ready;
    assign slot_free  = !frame_valid_q || bus.frame_ready;
    assign xfer       = slot_free && ((cnt_q == FULL) || ((state_q == ST_PEND) && (cnt_q != '0)));
    assign handshake  = frame_valid_q && bus.frame_ready;

    // A transfer clears the buffer first, so a same-cycle atom starts the next frame
    always_comb begin
        base_cnt = xfer ? '0 : cnt_q;
        pack_n   = xfer ? '0 : pack_q;
        cnt_n    = base_cnt;
        if (accept) begin
            pack_n[base_cnt*ATOM_W +: ATOM_W] = bus.atom_data;
            cnt_n = base_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        ended_n = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.flush) state_n = ST_PEND;
            ST_PEND: begin
                if (xfer) begin
                    state_n = ST_SENT;
                end else if ((cnt_q == '0) && !frame_valid_q) begin
                    state_n = ST_IDLE;
                    ended_n = 1'b1;
                end
            end
            ST_SENT: begin
                if (handshake) begin
                    state_n = ST_IDLE;
                    ended_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pack_q        <= '0;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_last_q  <= 1'b0;
            frame_data_q  <= '0;
            frame_count_q <= '0;
            ended_q       <= 1'b0;
        end else begin
            state_q <= state_n;
            pack_q  <= pack_n;
            cnt_q   <= cnt_n;
            ended_q <= ended_n;
            if (xfer) begin
                frame_valid_q <= 1'b1;
                frame_data_q  <= pack_q;
                frame_count_q <= cnt_q;
                frame_last_q  <= (state_q == ST_PEND);
            end else if (handshake) begin
                frame_valid_q <= 1'b0;
            end
        end
    end

    assign bus.atom_ready     = atom_ready;
    assign bus.frame_valid    = frame_valid_q;
    assign bus.frame_data     = frame_data_q;
    assign bus.frame_count    = frame_count_q;
    assign bus.frame_last     = frame_last_q;
    assign bus.dct_buffer     = pack_q;
    assign bus.dct_count      = cnt_q;
    assign bus.test_ending    = (state_q != ST_IDLE);
    assign bus.test_has_ended = ended_q;
endmodule

// File: tb/tb_usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer.sv
// Directed plus randomized bench for the DCT packer against a queue-based frame model.
module tb_usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer_if #(.ATOM_W(2), .BUF_W(30), .CNT_W(4)) bus ();

    usb20sr_refdes_cpu_qsys_gen2_cpu_oci_dct_packer #(
        .ATOM_W(2), .ATOMS(15), .BUF_W(30), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: atoms held as queues, flush tracked as two booleans
    int m_buf[$];
    int m_slot[$];
    bit m_v, m_last, m_pend, m_sent, m_end;

    function automatic logic [31:0] pack(input int q[$]);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < q.size(); i++) r = r | (32'(q[i]) << (2 * i));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit av, input int ad, input bit fl, input bit fr, input bit rst);
        int n;
        bit acc, sfree, hs, xf, was_pend, new_end;
        bus.atom_valid  = av;
        bus.atom_data   = 2'(ad);
        bus.flush       = fl;
        bus.frame_ready = fr;
        reset           = rst;
        n       = m_buf.size();
        acc     = av && (n != 15);
        sfree   = !m_v || fr;
        hs      = m_v && fr;
        xf      = sfree && (n == 15 || (m_pend && n != 0));
        was_pend = m_pend;
        new_end = 1'b0;
        if (rst) begin
            m_buf = {}; m_slot = {};
            m_v = 0; m_last = 0; m_pend = 0; m_sent = 0;
        end else begin
            if (m_pend && xf) begin
                m_pend = 0; m_sent = 1;
            end else if (m_pend && n == 0 && !m_v) begin
                m_pend = 0; new_end = 1;
            end else if (m_sent && hs) begin
                m_sent = 0; new_end = 1;
            end else if (!m_pend && !m_sent && fl) begin
                m_pend = 1;
            end
            if (xf) begin
                m_slot = m_buf; m_v = 1; m_last = was_pend; m_buf = {};
            end else if (hs) begin
                m_v = 0;
            end
            if (acc) m_buf.push_back(ad);
        end
        m_end = new_end;
        @(posedge clk);
        #1;
        chk("atom_ready", 32'(bus.atom_ready), 32'(m_buf.size() != 15));
        chk("dct_count", 32'(bus.dct_count), 32'(m_buf.size()));
        chk("dct_buffer", 32'(bus.dct_buffer), pack(m_buf));
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_v));
        chk("frame_data", 32'(bus.frame_data), pack(m_slot));
        chk("frame_count", 32'(bus.frame_count), 32'(m_slot.size()));
        chk("frame_last", 32'(bus.frame_last), 32'(m_last));
        chk("test_ending", 32'(bus.test_ending), 32'(m_pend || m_sent));
        chk("test_has_ended", 32'(bus.test_has_ended), 32'(m_end));
    endtask

    initial begin
        bus.atom_valid = 0; bus.atom_data = 0; bus.flush = 0; bus.frame_ready = 0; reset = 1;

        // Reset then idle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_ready", 32'(bus.atom_ready), 32'd1);
        chk("rst_fvalid", 32'(bus.frame_valid), 32'd0);
        step(0, 0, 0, 1, 0);

        // Full frame, values 1,2,3,0 repeating
        for (int i = 0; i < 15; i++) begin
            step(1, (i + 1) % 4, 0, 1, 0);
            chk("fill_cnt", 32'(bus.dct_count), 32'(i + 1));
        end
        step(0, 0, 0, 1, 0);
        chk("full_valid", 32'(bus.frame_valid), 32'd1);
        chk("full_data", 32'(bus.frame_data), 32'h3939_3939);
        chk("full_count", 32'(bus.frame_count), 32'd15);
        chk("full_last", 32'(bus.frame_last), 32'd0);
        chk("full_cnt0", 32'(bus.dct_count), 32'd0);
        step(0, 0, 0, 1, 0);

        // Backpressure: slot held, second buffer fills and stalls
        for (int i = 0; i < 32; i++) step(1, $urandom_range(0, 3), 0, 0, 0);
        chk("bp_ready", 32'(bus.atom_ready), 32'd0);
        chk("bp_valid", 32'(bus.frame_valid), 32'd1);
        chk("bp_cnt", 32'(bus.dct_count), 32'd15);
        step(1, 2, 0, 1, 0);
        chk("bp_release", 32'(bus.atom_ready), 32'd1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Partial flush of five 2'b11 atoms
        for (int i = 0; i < 5; i++) step(1, 3, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("pf_ending", 32'(bus.test_ending), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("pf_count", 32'(bus.frame_count), 32'd5);
        chk("pf_data", 32'(bus.frame_data), 32'h3FF);
        chk("pf_last", 32'(bus.frame_last), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("pf_ended", 32'(bus.test_has_ended), 32'd1);
        chk("pf_end_clr", 32'(bus.test_ending), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("pf_pulse", 32'(bus.test_has_ended), 32'd0);

        // Empty flush
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("ef_ended", 32'(bus.test_has_ended), 32'd1);
        chk("ef_novalid", 32'(bus.frame_valid), 32'd0);

        // Flush transfer with a same-cycle atom
        for (int i = 0; i < 3; i++) step(1, 2, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("fa_cnt", 32'(bus.dct_count), 32'd1);
        chk("fa_buf", 32'(bus.dct_buffer), 32'h1);
        chk("fa_count", 32'(bus.frame_count), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Reset mid-frame
        for (int i = 0; i < 7; i++) step(1, $urandom_range(0, 3), 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("rm_cnt", 32'(bus.dct_count), 32'd0);
        chk("rm_valid", 32'(bus.frame_valid), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("rm_none", 32'(bus.frame_valid), 32'd0);

        // Randomized traffic, flushes, backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, $urandom_range(0, 3), ($urandom % 25) == 0,
                 ($urandom % 3) != 0, ($urandom % 600) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
